// File: rtl/rr_decode_arbiter_pkg.sv
// Shared definitions for the round-robin decode arbiter.
//   N, IDXW   : requester count and decoder index width
//   state_e   : arbiter FSM encoding
//   lowest_set: index of the least-significant set bit of an N-bit vector
package rr_decode_arbiter_pkg;

    localparam int N    = 32;
    localparam int IDXW = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Priority find: lowest set bit wins; returns 0 for an all-zero vector
    // (callers qualify the result with their own "any" flag).
    function automatic logic [IDXW-1:0] lowest_set(input logic [N-1:0] v);
        logic [IDXW-1:0] pos;
        pos = 5'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                pos = IDXW'(i);
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/rr_decode_arbiter_dec.sv
// dec5to32: enable-gated 5-to-32 one-hot decoder.
//   x  [4:0]  : index
//   en        : enable; when low the output is all zero
//   y  [31:0] : one-hot of x when en=1
module dec5to32
    import rr_decode_arbiter_pkg::*;
(
    input  logic [IDXW-1:0] x,
    input  logic            en,
    output logic [N-1:0]    y
);

    // Decode the index into a single set bit, gated by enable.
    always_comb begin
        if (en) begin
            y = 32'd1 << x;
        end else begin
            y = 32'd0;
        end
    end

endmodule

// File: rtl/rr_decode_arbiter_pick.sv
// rr_pick: combinational round-robin winner selection.
//   req    [31:0] : request vector
//   ptr    [4:0]  : highest-priority position for this pick
//   winner [4:0]  : first set request at or after ptr, wrapping mod 32
//   any           : at least one request is set
module rr_pick
    import rr_decode_arbiter_pkg::*;
(
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] winner,
    output logic            any
);

    logic [N-1:0]    rot_s;
    logic [IDXW-1:0] off_s;

    // Rotate so ptr sits at bit 0, find the nearest request, then un-rotate;
    // the 5-bit add wraps naturally past index 31.
    always_comb begin
        rot_s  = N'({req, req} >> ptr);
        off_s  = lowest_set(rot_s);
        winner = ptr + off_s;
        any    = |req;
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: round-robin scheduler sharing one 5-to-32 decoder.
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   req   [31:0] : request vector, bit i = requester i
//   done         : current holder finished (ignored when no grant)
//   grant_idx [4:0]   : current/last winner index (registered)
//   grant_en          : grant valid (registered)
//   grant_onehot [31:0]: decoder output, one-hot of grant_idx when grant_en
//   preempt           : one-cycle pulse after a timeout-only release
module rr_decode_arbiter
    import rr_decode_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_en,
    output logic [N-1:0]    grant_onehot,
    output logic            preempt
);

    localparam int HCW = $clog2(MAX_HOLD) + 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [HCW-1:0] HOLD_ONE  = HCW'(1);

    state_e          state_r;
    logic [IDXW-1:0] ptr_r;
    logic [IDXW-1:0] grant_idx_r;
    logic            grant_en_r;
    logic            preempt_r;
    logic [HCW-1:0]  hold_cnt_r;

    logic [IDXW-1:0] winner_s;
    logic            any_s;
    logic            user_rel_s;
    logic            timeout_s;
    logic            release_s;

    rr_pick u_pick (
        .req    (req),
        .ptr    (ptr_r),
        .winner (winner_s),
        .any    (any_s)
    );

    // Release causes while granted; a user release (done or dropped
    // request) masks the timeout so no preempt is reported for it.
    always_comb begin
        user_rel_s = 1'b0;
        timeout_s  = 1'b0;
        release_s  = 1'b0;
        if (state_r == ST_GRANT) begin
            user_rel_s = done | ~req[grant_idx_r];
            timeout_s  = (hold_cnt_r == HOLD_LAST);
            release_s  = user_rel_s | timeout_s;
        end else begin
            user_rel_s = 1'b0;
            timeout_s  = 1'b0;
            release_s  = 1'b0;
        end
    end

    // Arbiter FSM with registered grant outputs; every release passes
    // through IDLE so consecutive grants are separated by one idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 5'd0;
            grant_idx_r <= 5'd0;
            grant_en_r  <= 1'b0;
            hold_cnt_r  <= '0;
            preempt_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    preempt_r <= 1'b0;
                    if (any_s) begin
                        grant_idx_r <= winner_s;
                        grant_en_r  <= 1'b1;
                        hold_cnt_r  <= '0;
                        state_r     <= ST_GRANT;
                    end else begin
                        grant_en_r  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        grant_en_r <= 1'b0;
                        ptr_r      <= grant_idx_r + 5'd1;
                        preempt_r  <= ~user_rel_s;
                        state_r    <= ST_IDLE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                        preempt_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    grant_en_r <= 1'b0;
                    preempt_r  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_idx = grant_idx_r;
    assign grant_en  = grant_en_r;
    assign preempt   = preempt_r;

    dec5to32 u_dec (
        .x  (grant_idx_r),
        .en (grant_en_r),
        .y  (grant_onehot)
    );

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Self-checking bench for rr_decode_arbiter: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_rr_decode_arbiter;

    localparam int MAX_HOLD = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] req;
    logic        done;
    logic [4:0]  grant_idx;
    logic        grant_en;
    logic [31:0] grant_onehot;
    logic        preempt;

    int n_tests;
    int n_fail;

    // Behavioural model state.
    bit m_busy;
    int m_idx;
    int m_held;   // cycles the current grant has been visible
    int m_ptr;
    bit m_pre;

    rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .done         (done),
        .grant_idx    (grant_idx),
        .grant_en     (grant_en),
        .grant_onehot (grant_onehot),
        .preempt      (preempt)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [38:0] obs;
    assign obs = {grant_en, grant_idx, preempt, grant_onehot};

    function automatic logic [38:0] model_outputs();
        logic [31:0] oh;
        logic [4:0]  ix;
        oh = 32'd0;
        if (m_busy) oh[m_idx] = 1'b1;
        ix = 5'(m_idx);
        return {m_busy, ix, m_pre, oh};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_idx = 0; m_held = 0; m_ptr = 0; m_pre = 1'b0;
    endtask

    // Advance the model by one clock edge from the inputs seen at that edge.
    task automatic model_edge(input logic [31:0] r, input logic d);
        bit found;
        bit user_rel;
        if (!m_busy) begin
            m_pre = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 32; k++) begin
                if (!found && r[(m_ptr + k) % 32]) begin
                    m_idx = (m_ptr + k) % 32;
                    found = 1'b1;
                end
            end
            if (found) begin
                m_busy = 1'b1;
                m_held = 1;
            end
        end else begin
            user_rel = d || !r[m_idx];
            if (user_rel || m_held == MAX_HOLD) begin
                m_busy = 1'b0;
                m_ptr  = (m_idx + 1) % 32;
                m_pre  = !user_rel;
            end else begin
                m_held = m_held + 1;
                m_pre  = 1'b0;
            end
        end
    endtask

    // Drive inputs, take one rising edge, update the model, settle at negedge.
    task automatic step(input logic [31:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(r, d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 32'd0;
        done  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (obs !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, 39'd0);
        end
    endtask

    task automatic test_single_done();
        do_reset();
        step(32'h0000_0001, 1'b0);
        n_tests++;
        if (grant_en !== 1'b1 || grant_idx !== 5'd0 || grant_onehot !== 32'h1) begin
            n_fail++;
            $display("FAIL single_grant: en=%b idx=%0d oh=%h expected en=1 idx=0 oh=00000001",
                     grant_en, grant_idx, grant_onehot);
        end
        for (int i = 0; i < 3; i++) begin
            step(32'h0000_0001, (i == 2) ? 1'b1 : 1'b0);
            n_tests++;
            if (obs !== model_outputs()) begin
                n_fail++;
                $display("FAIL single_hold[%0d]: got %h expected %h", i, obs, model_outputs());
            end
        end
        n_tests++;
        if (grant_en !== 1'b0 || preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: en=%b preempt=%b expected en=0 preempt=0", grant_en, preempt);
        end
        // ptr moved to 1: with bits 0 and 1 requested, index 1 must win.
        step(32'h0000_0003, 1'b0);
        n_tests++;
        if (grant_en !== 1'b1 || grant_idx !== 5'd1) begin
            n_fail++;
            $display("FAIL single_ptr_advance: en=%b idx=%0d expected en=1 idx=1", grant_en, grant_idx);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] seq [4];
        logic [4:0] want [4];
        int n;
        want[0] = 5'd0; want[1] = 5'd4; want[2] = 5'd31; want[3] = 5'd0;
        do_reset();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(32'h8000_0011, 1'b1);
            n_tests++;
            if (obs !== model_outputs()) begin
                n_fail++;
                $display("FAIL wrap_step[%0d]: got %h expected %h", i, obs, model_outputs());
            end
            if (grant_en === 1'b1 && n < 4) begin
                seq[n] = grant_idx;
                n++;
            end
        end
        n_tests++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d grants expected 4", n);
        end
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (seq[i] !== want[i]) begin
                n_fail++;
                $display("FAIL wrap_seq[%0d]: got %0d expected %0d", i, seq[i], want[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int hi;
        do_reset();
        step(32'h0000_0400, 1'b0);
        hi = 0;
        while (grant_en === 1'b1 && hi < 40) begin
            hi++;
            n_tests++;
            if (obs !== model_outputs()) begin
                n_fail++;
                $display("FAIL timeout_hold[%0d]: got %h expected %h", hi, obs, model_outputs());
            end
            step(32'h0000_0400, 1'b0);
        end
        n_tests++;
        if (hi != MAX_HOLD) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d cycles expected %0d", hi, MAX_HOLD);
        end
        n_tests++;
        if (preempt !== 1'b1 || grant_en !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_preempt: preempt=%b en=%b expected preempt=1 en=0", preempt, grant_en);
        end
        step(32'h0000_0400, 1'b0);
        n_tests++;
        if (grant_en !== 1'b1 || grant_idx !== 5'd10 || preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_regrant: en=%b idx=%0d preempt=%b expected en=1 idx=10 preempt=0",
                     grant_en, grant_idx, preempt);
        end
    endtask

    task automatic test_drop();
        do_reset();
        step(32'h0000_0060, 1'b0);
        step(32'h0000_0060, 1'b0);
        n_tests++;
        if (grant_en !== 1'b1 || grant_idx !== 5'd5) begin
            n_fail++;
            $display("FAIL drop_grant: en=%b idx=%0d expected en=1 idx=5", grant_en, grant_idx);
        end
        step(32'h0000_0040, 1'b0);
        n_tests++;
        if (grant_en !== 1'b0 || preempt !== 1'b0 || grant_idx !== 5'd5) begin
            n_fail++;
            $display("FAIL drop_release: en=%b preempt=%b idx=%0d expected en=0 preempt=0 idx=5",
                     grant_en, preempt, grant_idx);
        end
        step(32'h0000_0040, 1'b0);
        n_tests++;
        if (grant_en !== 1'b1 || grant_idx !== 5'd6) begin
            n_fail++;
            $display("FAIL drop_next: en=%b idx=%0d expected en=1 idx=6", grant_en, grant_idx);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(32'h0000_1000, 1'b0);
        step(32'h0000_1000, 1'b0);
        n_tests++;
        if (grant_en !== 1'b1 || grant_idx !== 5'd12) begin
            n_fail++;
            $display("FAIL areset_pre: en=%b idx=%0d expected en=1 idx=12", grant_en, grant_idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (grant_en !== 1'b0 || grant_onehot !== 32'd0) begin
            n_fail++;
            $display("FAIL areset_drop: en=%b oh=%h expected en=0 oh=00000000", grant_en, grant_onehot);
        end
        model_reset();
        req = 32'hFFFF_FFFF;
        @(negedge clk);
        rst_n = 1'b1;
        step(32'hFFFF_FFFF, 1'b0);
        n_tests++;
        if (grant_en !== 1'b1 || grant_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL areset_first: en=%b idx=%0d expected en=1 idx=0", grant_en, grant_idx);
        end
    endtask

    task automatic test_done_idle();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(32'd0, 1'b1);
            n_tests++;
            if (grant_en !== 1'b0 || grant_onehot !== 32'd0) begin
                n_fail++;
                $display("FAIL idle_done[%0d]: en=%b oh=%h expected en=0 oh=00000000",
                         i, grant_en, grant_onehot);
            end
        end
        step(32'h0000_0100, 1'b0);
        n_tests++;
        if (grant_en !== 1'b1 || grant_idx !== 5'd8 || grant_onehot !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL idle_grant: en=%b idx=%0d oh=%h expected en=1 idx=8 oh=00000100",
                     grant_en, grant_idx, grant_onehot);
        end
        for (int i = 0; i < 5; i++) begin
            step(32'h0000_0100, (i == 4) ? 1'b1 : 1'b0);
            n_tests++;
            if (obs !== model_outputs()) begin
                n_fail++;
                $display("FAIL idle_hold[%0d]: got %h expected %h", i, obs, model_outputs());
            end
        end
        n_tests++;
        if (grant_en !== 1'b0 || preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_own_done: en=%b preempt=%b expected en=0 preempt=0", grant_en, preempt);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic        d;
        int          mode;
        do_reset();
        r = 32'd0;
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 24 == 0) mode = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                case (mode)
                    0: r = $urandom & $urandom & $urandom;
                    1: r = 32'd1 << $urandom_range(0, 31);
                    2: r = $urandom;
                    default: r = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFF_FFFF;
                endcase
            end
            d = ($urandom_range(0, 9) == 0);
            step(r, d);
            n_tests++;
            if (obs !== model_outputs() || $countones(grant_onehot) > 1) begin
                n_fail++;
                $display("FAIL random[%0d]: req=%h done=%b got %h expected %h",
                         i, r, d, obs, model_outputs());
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req     = 32'd0;
        done    = 1'b0;
        model_reset();
        test_reset();
        test_single_done();
        test_wrap();
        test_timeout();
        test_drop();
        test_async_reset();
        test_done_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
